imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory. The CPU datapath only reads imem; this block fills it at run time from a byte-stream host port, so benches no longer need `$readmemb`.
- Sits in `computer` between an external byte source and the imem write port.
- Holds the CPU in reset while loading, then releases it so execution starts from PC 0.

Parameters:
- N, 32, instruction word width in bits; must be a multiple of 8.
- AW, 6, imem word-address width; capacity is 2**AW words.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load.
- word_count  in  AW+1  number of words to load; sampled on start.
- in_data  in  8  stream byte; MSB byte of each word first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  imem write strobe, one cycle per word.
- imem_addr  out  AW  imem word index.
- imem_wdata  out  N  assembled instruction word.
- cpu_reset  out  1  reset to the cpu/datapath.
- busy  out  1  load in progress.
- err  out  1  checksum failure (see Optional Feature).

Behaviour:
- Reset is asynchronous and active-high; all state is cleared while reset=1. Reset values:
  - state=IDLE
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_reset=1, busy=0, err=0
  - internal byte counter=0, word counter=0, remaining=0
- States:
  - IDLE:
    - cpu_reset=1, in_ready=0.
    - start=1 latches remaining=min(word_count, 2**AW) and clears the word counter.
    - If remaining=0, next state is DONE; otherwise next state is LOAD.
  - LOAD:
    - busy=1, in_ready=1.
    - A byte is accepted on a rising edge with in_valid&in_ready. It shifts into the assembly register: asm = {asm[N-9:0], in_data}.
    - The byte counter counts 0..N/8-1. On acceptance of byte N/8-1:
      - imem_wdata <= the full word;
      - imem_addr <= word counter;
      - imem_we <= 1 for exactly the next cycle;
      - word counter increments;
      - byte counter wraps to 0.
    - Byte acceptance continues during the imem_we cycle; no bubble is required.
    - After the write of word remaining-1, next state is CHECK if `IMEM_LOADER_CHECKSUM_EN` is defined, else DONE. in_ready=0 from that edge on.
  - CHECK: present only with `IMEM_LOADER_CHECKSUM_EN`; see Optional Feature.
  - DONE:
    - busy=0, in_ready=0.
    - cpu_reset deasserts one cycle after entry. The registered release guarantees the last imem write completes before the CPU leaves reset.
    - start=1 in DONE re-enters the load sequence as from IDLE. cpu_reset reasserts on that edge.
  - ERROR:
    - cpu_reset=1, err=1, in_ready=0.
    - Exit only via reset, or via start (which clears err).
- Boundary rules:
  - start while busy is ignored.
  - in_valid outside LOAD/CHECK is ignored; no bytes are consumed.
  - word_count > 2**AW is clamped to 2**AW. The address never wraps, and the final address is 2**AW-1.
  - A partial word is never written. Reset mid-load abandons it, and cpu_reset stays asserted.
  - Latency: last byte accepted on edge k → imem_we high in cycle k..k+1 → DONE at edge k+1 → cpu_reset low after edge k+2.

Optional Feature:
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - A running XOR of every accepted data byte is kept and cleared on start.
  - After the last word, the CHECK state accepts one more byte with in_ready=1.
  - If that byte equals the XOR, next state is DONE; otherwise next state is ERROR with err=1.
  - With word_count=0, CHECK still expects one byte equal to 8'h00.
- Undefined:
  - No CHECK state and no checksum register.
  - err is tied to 0.

Test Plan:
- Reset, then idle: reset pulse with no start → cpu_reset=1, in_ready=0, imem_we=0, busy=0 indefinitely.
- Two-word load:
  - Stimulus: start with word_count=2, then bytes 20,08,00,05, 20,09,00,0A with in_valid held high.
  - Required: imem_we pulses exactly twice, with (addr 0, 32'h20080005) and (addr 1, 32'h2009000A); busy drops; cpu_reset falls 2 cycles after the last byte.
- Stalls: same stream with in_valid=0 on alternate cycles → identical imem writes; no byte is lost or duplicated.
- Zero and clamp:
  - word_count=0 → DONE without any imem_we.
  - word_count=100 with AW=6 → exactly 64 writes; last addr=63.
- Mid-load reset: reset asserted after 6 bytes → only word 0 written; all outputs return to reset values; a fresh load then succeeds.
- Checksum (macro defined):
  - Stream 01,02,03,04 then checksum 04 → DONE, err=0.
  - Same stream with checksum 05 → ERROR, err=1, cpu_reset stays 1; a subsequent start clears err.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: fills imem from an MSB-first byte stream and holds the cpu in reset until the load completes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHECK/ERROR states, err output).
module imem_loader #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   word_count,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [N-1:0]  imem_wdata,
  output logic          cpu_reset,
  output logic          busy,
  output logic          err
);
  localparam int NB = N / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};
  localparam logic [BW-1:0] BLAST = BW'(NB - 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, DONE, CHECK, ERROR} state_t;
  localparam state_t FIN = CHECK;
`else
  typedef enum logic [2:0] {IDLE, LOAD, DONE} state_t;
  localparam state_t FIN = DONE;
`endif
  state_t state, state_n;
  logic [N-9:0] asm_q;
  logic [BW-1:0] bcnt;
  logic [AW:0] wcnt, remaining, clamped;
  logic [N-1:0] word;
  logic go, all_written, accept, word_done, checking;
  assign clamped = word_count > CAP ? CAP : word_count;
  assign word = {asm_q, in_data};
  assign all_written = wcnt == remaining;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign checking = state == CHECK;
  assign err = state == ERROR;
`else
  assign checking = 1'b0;
  assign err = 1'b0;
`endif
  assign go = start && (state == IDLE || state == DONE || err);
  assign busy = state == LOAD || checking;
  // in_ready drops on the edge that launches the final write, before LOAD is left
  assign in_ready = (state == LOAD && !all_written) || checking;
  assign accept = in_valid && in_ready;
  assign word_done = accept && state == LOAD && bcnt == BLAST;
  always_comb begin
    state_n = state;
    if (go) state_n = clamped == '0 ? FIN : LOAD;
    else if (state == LOAD && imem_we && all_written) state_n = FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
    else if (checking && accept) state_n = in_data == csum ? DONE : ERROR;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      asm_q      <= '0;
      bcnt       <= '0;
      wcnt       <= '0;
      remaining  <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
    end else begin
      state     <= state_n;
      imem_we   <= word_done;
      cpu_reset <= !(state == DONE && !go);
      if (go) begin
        remaining <= clamped;
        wcnt      <= '0;
        bcnt      <= '0;
      end
      if (accept && state == LOAD) begin
        asm_q <= word[N-9:0];
        bcnt  <= word_done ? '0 : bcnt + 1'b1;
      end
      if (word_done) begin
        imem_wdata <= word;
        imem_addr  <= wcnt[AW-1:0];
        wcnt       <= wcnt + 1'b1;
      end
    end
  end
`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) csum <= '0;
    else if (go) csum <= '0;
    else if (accept && state == LOAD) csum <= csum ^ in_data;
  end
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader; checksum scenarios build with IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
  localparam int N  = 32;
  localparam int AW = 6;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [AW:0] word_count = '0;
  logic [7:0] in_data = '0;
  logic in_ready, imem_we, cpu_reset, busy, err;
  logic [AW-1:0] imem_addr;
  logic [N-1:0] imem_wdata;
  int tests = 0;
  int fails = 0;
  int wr_n = 0;
  logic [AW-1:0] wa [0:1023];
  logic [N-1:0] wd [0:1023];
  logic [31:0] words [0:63];

  always #5 clk = ~clk;

  imem_loader #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .err(err)
  );

  always @(negedge clk) begin
    if (imem_we && wr_n < 1024) begin
      wa[wr_n] = imem_addr;
      wd[wr_n] = imem_wdata;
      wr_n = wr_n + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_byte timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_words(input int n, input int gap);
    logic [7:0] cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int j = 3; j >= 0; j--) begin
        logic [7:0] b;
        b = words[i][8*j +: 8];
        cs ^= b;
        repeat (gap) @(negedge clk);
        send_byte(b);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs);
`endif
  endtask

  task automatic do_start(input int wc);
    word_count = wc[AW:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    repeat (3) @(negedge clk);
    tests++;
    if ({cpu_reset, in_ready, imem_we, busy, err} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_flags: got %b required 10000", {cpu_reset, in_ready, imem_we, busy, err});
    end
    tests++;
    if ({imem_addr, imem_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_bus: got addr=%h data=%h required 0", imem_addr, imem_wdata);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if ({cpu_reset, in_ready, imem_we, busy, err} !== 5'b10000) begin
      fails++;
      $display("FAIL idle_flags: got %b required 10000", {cpu_reset, in_ready, imem_we, busy, err});
    end
    in_valid = 1'b0;
    #1;
    tests++;
    if (wr_n !== 0) begin
      fails++;
      $display("FAIL idle_writes: got %0d required 0", wr_n);
    end
  endtask

  task automatic test_two_word(input int gap);
    int base = wr_n;
    words[0] = 32'h20080005;
    words[1] = 32'h2009000A;
    do_start(2);
    tests++;
    if ({busy, cpu_reset, in_ready} !== 3'b111) begin
      fails++;
      $display("FAIL load_entry gap=%0d: got busy,cpu_reset,in_ready=%b required 111", gap, {busy, cpu_reset, in_ready});
    end
    send_words(2, gap);
    tests++;
    if ({in_ready, cpu_reset} !== 2'b01) begin
      fails++;
      $display("FAIL last_edge gap=%0d: got in_ready,cpu_reset=%b required 01", gap, {in_ready, cpu_reset});
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    tests++;
    if ({busy, cpu_reset} !== 2'b01) begin
      fails++;
      $display("FAIL done_entry gap=%0d: got busy,cpu_reset=%b required 01", gap, {busy, cpu_reset});
    end
`endif
    @(negedge clk);
    tests++;
    if ({busy, cpu_reset} !== 2'b00) begin
      fails++;
      $display("FAIL release gap=%0d: got busy,cpu_reset=%b required 00", gap, {busy, cpu_reset});
    end
    #1;
    tests++;
    if (wr_n - base !== 2) begin
      fails++;
      $display("FAIL write_count gap=%0d: got %0d required 2", gap, wr_n - base);
    end
    tests++;
    if (wa[base] !== 6'd0 || wd[base] !== 32'h20080005) begin
      fails++;
      $display("FAIL word0 gap=%0d: got addr=%0d data=%h required addr=0 data=20080005", gap, wa[base], wd[base]);
    end
    tests++;
    if (wa[base+1] !== 6'd1 || wd[base+1] !== 32'h2009000A) begin
      fails++;
      $display("FAIL word1 gap=%0d: got addr=%0d data=%h required addr=1 data=2009000a", gap, wa[base+1], wd[base+1]);
    end
  endtask

  task automatic test_zero;
    int base = wr_n;
    do_start(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    in_valid = 1'b1;
    in_data = 8'h77;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests++;
    if ({cpu_reset, busy, in_ready, err} !== 4'b0000) begin
      fails++;
      $display("FAIL zero_done: got cpu_reset,busy,in_ready,err=%b required 0000", {cpu_reset, busy, in_ready, err});
    end
    tests++;
    if (wr_n - base !== 0) begin
      fails++;
      $display("FAIL zero_writes: got %0d required 0", wr_n - base);
    end
  endtask

  task automatic test_clamp;
    int base = wr_n;
    int bad = 0;
    for (int i = 0; i < 64; i++) words[i] = {8'(i), 8'hA5, ~8'(i), 8'h3C};
    do_start(100);
    send_words(64, 0);
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (wr_n - base !== 64) begin
      fails++;
      $display("FAIL clamp_count: got %0d required 64", wr_n - base);
    end
    tests++;
    if (wa[base+63] !== 6'd63 || wd[base+63] !== 32'h3FA5C03C) begin
      fails++;
      $display("FAIL clamp_last: got addr=%0d data=%h required addr=63 data=3fa5c03c", wa[base+63], wd[base+63]);
    end
    for (int i = 0; i < 64; i++) if (wa[base+i] !== 6'(i) || wd[base+i] !== words[i]) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL clamp_all: got %0d bad words required 0", bad);
    end
    tests++;
    if ({cpu_reset, busy} !== 2'b00) begin
      fails++;
      $display("FAIL clamp_release: got cpu_reset,busy=%b required 00", {cpu_reset, busy});
    end
  endtask

  task automatic test_mid_reset;
    int base = wr_n;
    logic [7:0] bytes [0:5];
    bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09};
    do_start(2);
    for (int i = 0; i < 6; i++) begin
      send_byte(bytes[i]);
      if (i == 1) do_start(0);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({cpu_reset, in_ready, imem_we, busy, err} !== 5'b10000 || {imem_addr, imem_wdata} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got flags=%b addr=%h data=%h required 10000 0 0",
               {cpu_reset, in_ready, imem_we, busy, err}, imem_addr, imem_wdata);
    end
    tests++;
    if (wr_n - base !== 1 || wd[base] !== 32'h20080005) begin
      fails++;
      $display("FAIL midreset_writes: got count=%0d data=%h required 1 20080005", wr_n - base, wd[base]);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_two_word(0);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    do_start(1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h04);
    @(negedge clk);
    tests++;
    if ({err, cpu_reset, busy} !== 3'b000) begin
      fails++;
      $display("FAIL csum_good: got err,cpu_reset,busy=%b required 000", {err, cpu_reset, busy});
    end
    do_start(1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05);
    repeat (3) @(negedge clk);
    tests++;
    if ({err, cpu_reset, in_ready, busy} !== 4'b1100) begin
      fails++;
      $display("FAIL csum_bad: got err,cpu_reset,in_ready,busy=%b required 1100", {err, cpu_reset, in_ready, busy});
    end
    do_start(1);
    tests++;
    if ({err, busy} !== 2'b01) begin
      fails++;
      $display("FAIL csum_restart: got err,busy=%b required 01", {err, busy});
    end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h04);
    @(negedge clk);
    tests++;
    if ({err, cpu_reset} !== 2'b00) begin
      fails++;
      $display("FAIL csum_recover: got err,cpu_reset=%b required 00", {err, cpu_reset});
    end
  endtask
`endif

  initial begin
    test_reset;
    test_two_word(0);
    test_two_word(1);
    test_zero;
    test_clamp;
    test_mid_reset;
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
